uart_rx_two_bytes: RTL and testbench

- Receive-side counterpart to the two-byte UART transmitter top in the ice40 uncore.
- Samples an asynchronous 8N1 serial line and pairs consecutive bytes into a 16-bit word.
- Presents each word on a valid/ready interface and drives two debug LEDs.
- Sits between the board rx pin and XLS-generated logic that consumes 16-bit words.

---
 rtl/uart_rx_two_bytes.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_two_bytes.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_two_bytes.sv
// 8N1 UART receiver pairing consecutive bytes into 16-bit words on a valid/ready port.
// Optional idle timeout for a dangling first byte: define UART_RX_TWO_BYTES_TIMEOUT_EN.
module uart_rx_two_bytes #(
    parameter int ClocksPerBaud = 4,
    parameter int TimeoutBauds  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_in,
    output logic [15:0] word_out,
    output logic        word_valid_out,
    input  logic        word_ready_in,
    output logic        framing_error_out,
    output logic        overrun_out,
    output logic        led_left_out,
    output logic        led_center_out
);
    localparam int CntW = $clog2(ClocksPerBaud) + 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(ClocksPerBaud / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(ClocksPerBaud - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state, state_nxt;
    logic [CntW-1:0] cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            rx_meta, rxs;
    logic            byte_ok, frame_err, timeout;
    logic            byte_idx, word_done;
    logic [7:0]      hold;
    logic [15:0]     word_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx_in;
            rxs     <= rx_meta;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CntW'(1);
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rxs) state_nxt = START;
            end
            START: begin
                if (cnt == HalfLast) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FullLast) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rxs, shreg[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == FullLast) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        byte_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_TWO_BYTES_TIMEOUT_EN
    localparam int TLim = TimeoutBauds * ClocksPerBaud;
    localparam int TW   = $clog2(TLim) + 1;
    logic [TW-1:0] tcnt;

    // Counts idle cycles only while a first byte is waiting for its partner.
    always_ff @(posedge clk) begin
        if (!rst_n || state != IDLE || !byte_idx) tcnt <= '0;
        else if (!timeout)                        tcnt <= tcnt + TW'(1);
    end

    assign timeout = byte_idx && (state == IDLE) && (tcnt == TW'(TLim - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx  <= 1'b0;
            hold      <= '0;
            word_done <= 1'b0;
            word_pend <= '0;
        end else begin
            word_done <= 1'b0;
            if (byte_ok) begin
                if (!byte_idx) begin
                    hold     <= shreg;
                    byte_idx <= 1'b1;
                end else begin
                    word_pend <= {hold, shreg};
                    word_done <= 1'b1;
                    byte_idx  <= 1'b0;
                end
            end else if (frame_err || timeout) begin
                byte_idx <= 1'b0;
            end
        end
    end

    // A new word replaces the current one only if that one is gone or being accepted now.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_out          <= '0;
            word_valid_out    <= 1'b0;
            framing_error_out <= 1'b0;
            overrun_out       <= 1'b0;
            led_center_out    <= 1'b0;
        end else begin
            if (frame_err) framing_error_out <= 1'b1;
            if (word_done) begin
                if (!word_valid_out || word_ready_in) begin
                    word_out       <= word_pend;
                    word_valid_out <= 1'b1;
                    led_center_out <= ~led_center_out;
                end else begin
                    overrun_out <= 1'b1;
                end
            end else if (word_valid_out && word_ready_in) begin
                word_valid_out <= 1'b0;
            end
        end
    end

    assign led_left_out = framing_error_out | overrun_out;
endmodule

// File: tb/tb_uart_rx_two_bytes.sv
// Directed bench for uart_rx_two_bytes at ClocksPerBaud=4, TimeoutBauds=16.
module tb_uart_rx_two_bytes;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_in = 1'b1;
    logic [15:0] word_out;
    logic        word_valid_out;
    logic        word_ready_in = 1'b1;
    logic        framing_error_out;
    logic        overrun_out;
    logic        led_left_out;
    logic        led_center_out;

    int          checks = 0;
    int          failures = 0;
    int          valid_cycles = 0;
    logic [15:0] last_word = '0;
    int          vc0;

    uart_rx_two_bytes #(.ClocksPerBaud(4), .TimeoutBauds(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_in(rx_in),
        .word_out(word_out),
        .word_valid_out(word_valid_out),
        .word_ready_in(word_ready_in),
        .framing_error_out(framing_error_out),
        .overrun_out(overrun_out),
        .led_left_out(led_left_out),
        .led_center_out(led_center_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid_out) begin
            valid_cycles = valid_cycles + 1;
            last_word    = word_out;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0, 4);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 4);
        drive_bit(stop, 4);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"}, word_out, 16'h0000);
        check({tag, "_valid"}, {15'd0, word_valid_out}, 16'd0);
        check({tag, "_ferr"}, {15'd0, framing_error_out}, 16'd0);
        check({tag, "_ovr"}, {15'd0, overrun_out}, 16'd0);
        check({tag, "_ledl"}, {15'd0, led_left_out}, 16'd0);
        check({tag, "_ledc"}, {15'd0, led_center_out}, 16'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        check_all_zero("reset");

        // Back-to-back pair with consumer always ready
        word_ready_in = 1'b1;
        vc0 = valid_cycles;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle(8);
        check("t1_word", last_word, 16'hA53C);
        check("t1_vcycles", 16'(valid_cycles - vc0), 16'd1);
        check("t1_ledc", {15'd0, led_center_out}, 16'd1);
        check("t1_ferr", {15'd0, framing_error_out}, 16'd0);
        check("t1_ovr", {15'd0, overrun_out}, 16'd0);

        // Stalled consumer: second word is dropped
        do_reset();
        word_ready_in = 1'b0;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(8);
        check("t2_word1", word_out, 16'h1234);
        check("t2_valid1", {15'd0, word_valid_out}, 16'd1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        idle(8);
        check("t2_ovr", {15'd0, overrun_out}, 16'd1);
        check("t2_ledl", {15'd0, led_left_out}, 16'd1);
        check("t2_word_kept", word_out, 16'h1234);
        check("t2_valid_kept", {15'd0, word_valid_out}, 16'd1);
        check("t2_ledc", {15'd0, led_center_out}, 16'd1);
        word_ready_in = 1'b1;
        @(posedge clk);
        #1;
        check("t2_valid_drop", {15'd0, word_valid_out}, 16'd0);

        // Framing error on a stop bit, then a clean pair
        do_reset();
        vc0 = valid_cycles;
        send_byte(8'h55, 1'b0);
        idle(8);
        check("t3_ferr", {15'd0, framing_error_out}, 16'd1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(8);
        check("t3_word", last_word, 16'h0102);
        check("t3_vcycles", 16'(valid_cycles - vc0), 16'd1);
        check("t3_ledl", {15'd0, led_left_out}, 16'd1);

        // One-cycle glitch while idle must not register as a byte
        do_reset();
        vc0 = valid_cycles;
        drive_bit(1'b0, 1);
        idle(20);
        check("t4_vcycles", 16'(valid_cycles - vc0), 16'd0);
        check("t4_ferr", {15'd0, framing_error_out}, 16'd0);
        check("t4_ovr", {15'd0, overrun_out}, 16'd0);
        send_byte(8'hC3, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle(8);
        check("t4_word", last_word, 16'hC35A);

        // Reset during bit 4 of the second byte
        send_byte(8'h12, 1'b1);
        drive_bit(1'b0, 4);
        drive_bit(1'b0, 4);
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 4);
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 2);
        rst_n = 1'b0;
        rx_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("t5_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        vc0 = valid_cycles;
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(8);
        check("t5_word", last_word, 16'hBEEF);
        check("t5_vcycles", 16'(valid_cycles - vc0), 16'd1);

        // Long idle between first and second byte
        do_reset();
        send_byte(8'hAA, 1'b1);
        idle(80);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(8);
`ifdef UART_RX_TWO_BYTES_TIMEOUT_EN
        check("t6_word", last_word, 16'h1122);
`else
        check("t6_word", last_word, 16'hAA11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
